// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared types and constants for the RV32M multiply/divide unit
// Purpose: operation encoding (equal to funct3), FSM state type, decode and
//          special-case constants, and small operation-class helpers.
// Ports: none (package).
package rv32m_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [6:0]  F7_MULDIV = 7'h01;
  localparam logic [31:0] DIV0_Q    = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // MUL low word is sign-agnostic; treating it as signed keeps one datapath.
  function automatic logic op_rs1_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_rs2_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/rv32m_div_iter.sv
// rtl/rv32m_div_iter.sv - one combinational restoring-division step
// Purpose: shifts the next dividend bit into the partial remainder, subtracts
//          the divisor when it fits, and shifts the quotient bit in.
// Ports:
//   rem_in   in  XLEN  partial remainder (always < divisor)
//   quo_in   in  XLEN  dividend bits not yet consumed / quotient bits so far
//   divisor  in  XLEN  divisor magnitude
//   rem_out  out XLEN  next partial remainder
//   quo_out  out XLEN  next dividend/quotient word
module rv32m_div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    fits    = (shifted >= {1'b0, divisor});
    // The remainder stays below the divisor, so the restored or reduced
    // value always fits back into XLEN bits.
    rem_out = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], fits};
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// rtl/rv32m_muldiv_unit.sv - multi-cycle RV32M multiply/divide execute unit
// Purpose: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with valid/ready handshake.
//          Iterative path: IDLE -> CALC (XLEN steps) -> FIX (sign) -> DONE.
//          Divide-by-zero and signed overflow resolve directly to DONE.
// Config macro: RV32M_FAST_MUL_EN - multiplies use a single-cycle 33x33 signed
//          product at the accept edge; otherwise multiply is shift-add.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   f7_m, f3            M-extension select and operation
//   rs1, rs2            operands
//   kill                synchronous flush to IDLE
//   out_valid/out_ready result handshake
//   result              RV32M result, stable while out_valid
//   busy                state != IDLE
module rv32m_muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            f7_m,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  muldiv_op_e        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opb_q;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient in}.
  logic [2*XLEN-1:0] acc_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;

  // ---------------- accept-side decode ----------------
  muldiv_op_e      op_in;
  logic            accept;
  logic            a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special_hit;
  logic [XLEN-1:0] special_result;

  always_comb begin
    op_in  = muldiv_op_e'(f3);
    accept = in_valid & (state_q == IDLE) & f7_m & ~kill;
    a_neg  = op_rs1_signed(op_in) & rs1[XLEN-1];
    b_neg  = op_rs2_signed(op_in) & rs2[XLEN-1];
    a_mag  = a_neg ? -rs1 : rs1;
    b_mag  = b_neg ? -rs2 : rs2;
    // Remainder follows the dividend sign; everything else the sign product.
    neg_in = op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);

    div_zero    = op_is_div(op_in) & (rs2 == '0);
    div_ovf     = (op_in inside {OP_DIV, OP_REM}) & (rs1 == INT_MIN) & (rs2 == '1);
    special_hit = div_zero | div_ovf;
    if (div_zero)
      special_result = op_is_rem(op_in) ? rs1 : DIV0_Q;
    else
      special_result = op_is_rem(op_in) ? '0 : INT_MIN;
  end

  // ---------------- optional single-cycle multiply ----------------
  logic            fast_hit;
  logic [XLEN-1:0] fast_result;

`ifdef RV32M_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN+1:0] fm_p;

  always_comb begin
    // One extra bit per operand lets a single signed multiplier cover
    // signed, unsigned and mixed-sign forms.
    fm_a        = {op_rs1_signed(op_in) & rs1[XLEN-1], rs1};
    fm_b        = {op_rs2_signed(op_in) & rs2[XLEN-1], rs2};
    fm_p        = fm_a * fm_b;
    fast_hit    = ~op_is_div(op_in);
    fast_result = (op_in == OP_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    fast_hit    = 1'b0;
    fast_result = '0;
  end
`endif

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN-1:0]   div_rem, div_quo;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
  end

  rv32m_div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_in  (acc_q[2*XLEN-1:XLEN]),
    .quo_in  (acc_q[XLEN-1:0]),
    .divisor (opb_q),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  // ---------------- sign fix and result select ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_result = quo_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      opb_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (kill) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            opb_q <= b_mag;
            acc_q <= {{XLEN{1'b0}}, a_mag};
            cnt_q <= '0;
            if (special_hit) begin
              result_q    <= special_result;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (fast_hit) begin
              result_q    <= fast_result;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          // Counter saturates at XLEN; the terminal cycle only hands over to FIX.
          if (cnt_q == CNT_W'(XLEN)) begin
            state_q <= FIX;
          end else begin
            acc_q <= op_is_div(op_q) ? {div_rem, div_quo} : mul_next;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          result_q    <= fix_result;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
